sccb_reg_seq: RTL
=================

SCCB_REG_SEQ -- requirements
Module: sccb_reg_seq

Interface
REQ-001 Parameter DEV_ADDR, default 8'h78: 8-bit SCCB write address of the sensor; the read address is DEV_ADDR|1.
REQ-002 Parameter ADDR_W, default 16: register address width (8 or 16).
REQ-003 Parameter DATA_W, default 8: register data width.
REQ-004 Parameter DEPTH, default 357: number of table entries, at least 1.
REQ-005 Parameter MAX_RETRY, default 3: extra attempts per entry after a failure.
REQ-006 Parameter CLK_HZ, default 25_000_000: clk frequency; the delay-entry prescaler is CLK_HZ/1000.
REQ-007 Derived constant IDX_W = clog2(DEPTH+1); DELAY_MARK = all-ones ADDR_W.
REQ-008 clk  in  1  single clock for all logic.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 start  in  1  one-cycle pulse that starts or restarts the sequence.
REQ-011 verify_en  in  1  read back and compare each write; sampled at start.
REQ-012 tbl_idx  out  IDX_W  table index to an external ROM.
REQ-013 tbl_entry  in  ADDR_W+DATA_W  {addr,data}; valid 1 cycle after tbl_idx changes.
REQ-014 txn_valid/txn_ready  out/in  1  transaction handshake to the I2C byte engine.
REQ-015 txn_rd  out  1  1 = read, 0 = write.
REQ-016 txn_dev  out  8  device address.
REQ-017 txn_addr  out  ADDR_W  register address.
REQ-018 txn_wdata  out  DATA_W  register write data.
REQ-019 txn_done  in  1  one-cycle pulse marking the end of a transaction.
REQ-020 txn_nack  in  1  NACK status; valid with txn_done.
REQ-021 txn_rdata  in  DATA_W  read data; valid with txn_done.
REQ-022 busy, done, error  out  1  status flags.
REQ-023 err_idx  out  IDX_W  index of the entry that failed.

Function
REQ-024 FSM states and order: IDLE -> FETCH -> LATCH -> {DELAY | WRITE -> WAIT_W -> [READ -> WAIT_R -> CHECK]} -> NEXT -> FETCH, or NEXT -> DONE; a failure goes to ERR.
REQ-025 FETCH drives tbl_idx; LATCH registers tbl_entry exactly one cycle later.
REQ-026 txn_valid, txn_rd, txn_dev, txn_addr and txn_wdata hold stable from assertion until the cycle txn_valid&&txn_ready is sampled high; txn_valid drops the following cycle.
REQ-027 WAIT_W/WAIT_R ignore txn_done until the handshake has completed.
REQ-028 A write failure is txn_nack=1 at txn_done.
REQ-029 A verify failure is txn_nack=1 on the read, or txn_rdata != latched data.
REQ-030 A failure with attempts <= MAX_RETRY re-enters WRITE for the same entry and increments the attempt count.
REQ-031 When the attempt count exceeds MAX_RETRY: go to ERR, error=1, err_idx=current index, busy=0.
REQ-032 The attempt count clears at each NEXT.
REQ-033 An entry with addr==DELAY_MARK issues no transaction and waits data x (CLK_HZ/1000) cycles in DELAY.
REQ-034 A delay entry with data=0 leaves DELAY on the next cycle.
REQ-035 NEXT at index DEPTH-1 goes to DONE: done=1, busy=0, tbl_idx holds DEPTH-1.
REQ-036 Any other NEXT increments the index by 1; the index never wraps.
REQ-037 start in IDLE, DONE or ERR resets the index to 0, clears done, error and err_idx, and sets busy the next cycle.
REQ-038 start while busy is ignored.
REQ-039 With verify_en=0, NEXT follows WAIT_W directly.

Reset
REQ-040 On rst: state=IDLE; busy=0, done=0, error=0, txn_valid=0; tbl_idx, err_idx, txn_* buses, attempt count and delay counters = 0.
REQ-041 rst mid-transaction abandons the transaction immediately with no further txn_valid; the external engine is reset by the same rst.
REQ-042 rst has priority over start in the same cycle.

Structure
REQ-043 Package sccb_pkg holds: the state enum, DELAY_MARK, clog2-based width helpers, and the default DEV_ADDR (8'h78).
REQ-044 One sub-module, sccb_ms_tick: a free-running 1 ms strobe generator parametrised by CLK_HZ, cleared on rst; DELAY counts its strobes after a prescaler realignment on entry.
REQ-045 Target size is 120-400 lines; the I2C bit engine and the table ROM are external.

Verification
REQ-046 DEPTH=3 table {3008_82, 3103_11, 4300_60}, always-ack engine, verify_en=0, start -> exactly 3 writes in index order with matching addr/data; done=1 after the third txn_done; busy=0.
REQ-047 Entry 1 NACKed twice, MAX_RETRY=3 -> entry 1 written 3 times; done=1, error=0.
REQ-048 Entry 1 always NACKed -> 4 attempts on entry 1; error=1, err_idx=1, entry 2 never issued; a following start reruns from index 0 with error cleared.
REQ-049 Delay entry {FFFF, 05} with CLK_HZ=10_000 -> no txn_valid for 50 +/- 10 cycles, then the next entry is issued; {FFFF, 00} -> next FETCH within 2 cycles.
REQ-050 verify_en=1 with read-back 0x81 for a write of 0x82 -> the entry is rewritten and reread per the retry rule; read transactions carry txn_rd=1 and txn_dev=0x78.
REQ-051 rst asserted during WAIT_W and txn_ready held low for 5 cycles -> all REQ-040 reset values hold next cycle; start during busy has no effect.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and width helpers for the SCCB register-table sequencer.
package sccb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DELAY,
    S_WRITE,
    S_WAIT_W,
    S_READ,
    S_WAIT_R,
    S_CHECK,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0]  DEFAULT_DEV_ADDR = 8'h78;
  // Truncated to ADDR_W at the point of use, so it is all-ones for any width.
  localparam logic [31:0] DELAY_MARK       = '1;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sccb_reg_seq_if.sv
// Transaction channel between the table sequencer and the external I2C byte engine.
interface sccb_reg_seq_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic              rd;
  logic [7:0]        dev;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              done;
  logic              nack;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, rd, dev, addr, wdata, input ready, done, nack, rdata);
  modport slave  (input valid, rd, dev, addr, wdata, output ready, done, nack, rdata);
endinterface

// File: rtl/sccb_ms_tick.sv
// Free-running 1 ms strobe; clr realigns the prescaler so a delay starts on a full period.
module sccb_ms_tick
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_HZ = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PRESCALE = ((CLK_HZ / 1000) < 1) ? 1 : (CLK_HZ / 1000);
  localparam int unsigned CW       = cnt_width(PRESCALE - 1);
  localparam logic [CW-1:0] LAST   = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/sccb_reg_seq.sv
// Walks an external {addr,data} register table, issuing SCCB writes (optionally read-back
// verified) with per-entry retry, and honouring millisecond delay entries.
module sccb_reg_seq
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR  = DEFAULT_DEV_ADDR,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 357,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned CLK_HZ    = 25_000_000,
  localparam int unsigned IDX_W    = idx_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     verify_en,
  output logic [IDX_W-1:0]         tbl_idx,
  input  logic [ADDR_W+DATA_W-1:0] tbl_entry,
  sccb_reg_seq_if.master           txn,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [IDX_W-1:0]         err_idx
);

  localparam int unsigned ATT_W        = cnt_width(MAX_RETRY + 1);
  localparam logic [ADDR_W-1:0] MARK   = ADDR_W'(DELAY_MARK);
  localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(DEPTH - 1);
  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_RETRY);

  state_t            state;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] dly_cnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_nack;
  logic              verify;
  logic              hs_done;
  logic [ATT_W-1:0]  attempt;
  logic [ADDR_W-1:0] ent_addr;
  logic [DATA_W-1:0] ent_data;
  logic              tick_clr;
  logic              ms_tick;

  assign ent_addr = tbl_entry[ADDR_W+DATA_W-1:DATA_W];
  assign ent_data = tbl_entry[DATA_W-1:0];
  assign tick_clr = (state == S_LATCH);

  sccb_ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (ms_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tbl_idx   <= '0;
      err_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      verify    <= 1'b0;
      attempt   <= '0;
      dly_cnt   <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      rd_data   <= '0;
      rd_nack   <= 1'b0;
      hs_done   <= 1'b0;
      txn.valid <= 1'b0;
      txn.rd    <= 1'b0;
      txn.dev   <= '0;
      txn.addr  <= '0;
      txn.wdata <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            tbl_idx <= '0;
            err_idx <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b1;
            verify  <= verify_en;
            attempt <= '0;
            state   <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          lat_addr <= ent_addr;
          lat_data <= ent_data;
          dly_cnt  <= ent_data;
          state    <= (ent_addr == MARK) ? S_DELAY : S_WRITE;
        end
        S_DELAY: begin
          if (dly_cnt == '0)  state   <= S_NEXT;
          else if (ms_tick)   dly_cnt <= dly_cnt - 1'b1;
        end
        S_WRITE: begin
          txn.valid <= 1'b1;
          txn.rd    <= 1'b0;
          txn.dev   <= DEV_ADDR;
          txn.addr  <= lat_addr;
          txn.wdata <= lat_data;
          hs_done   <= 1'b0;
          state     <= S_WAIT_W;
        end
        S_WAIT_W: begin
          if (txn.valid && txn.ready) begin
            txn.valid <= 1'b0;
            hs_done   <= 1'b1;
          end else if (hs_done && txn.done) begin
            if (!txn.nack)                 state <= verify ? S_READ : S_NEXT;
            else if (attempt == ATT_MAX) begin
              state   <= S_ERR;
              error   <= 1'b1;
              err_idx <= tbl_idx;
              busy    <= 1'b0;
            end else begin
              attempt <= attempt + 1'b1;
              state   <= S_WRITE;
            end
          end
        end
        // The engine forms the on-wire read address (DEV_ADDR|1) from txn.rd.
        S_READ: begin
          txn.valid <= 1'b1;
          txn.rd    <= 1'b1;
          txn.dev   <= DEV_ADDR;
          txn.addr  <= lat_addr;
          txn.wdata <= lat_data;
          hs_done   <= 1'b0;
          state     <= S_WAIT_R;
        end
        S_WAIT_R: begin
          if (txn.valid && txn.ready) begin
            txn.valid <= 1'b0;
            hs_done   <= 1'b1;
          end else if (hs_done && txn.done) begin
            rd_nack <= txn.nack;
            rd_data <= txn.rdata;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!rd_nack && (rd_data == lat_data)) state <= S_NEXT;
          else if (attempt == ATT_MAX) begin
            state   <= S_ERR;
            error   <= 1'b1;
            err_idx <= tbl_idx;
            busy    <= 1'b0;
          end else begin
            attempt <= attempt + 1'b1;
            state   <= S_WRITE;
          end
        end
        S_NEXT: begin
          attempt <= '0;
          if (tbl_idx == LAST_IX) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            tbl_idx <= tbl_idx + 1'b1;
            state   <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
